// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: picks one winner from NUM_REQ request lines, using either
// fixed priority (lowest index wins) or round robin from rr_ptr. The winner is
// held in a registered valid/ready slot as a one-hot vector plus a binary index.
// The grant is sticky until the consumer accepts it. On acceptance the slot is
// refilled in the same cycle, which allows one grant per cycle. Re-arbitration
// on an accepting edge uses the already-advanced round-robin pointer.

module rr_grant_encoder #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mode,
  input  logic               grant_ready,
  output logic               grant_valid,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [IDX_W-1:0]   rr_ptr
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] onehot_q, onehot_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic               handshake;
  logic               any_req;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic               hi_found;
  logic [IDX_W-1:0]   hi_idx;
  logic [IDX_W-1:0]   lo_idx;

  // Handshake detection and round-robin pointer advance. ptr_d is also the
  // forwarded pointer used by the arbiter on an accepting edge.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so that no path leaves it unassigned and infers a latch.
    handshake = (state_q == GRANT) && grant_ready;
    any_req   = |req;
    ptr_d     = ptr_q;
    if (handshake && mode) begin
      ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Arbiter: the lowest set bit at or above the start index wins. If there is
  // none, the lowest set bit overall wins, which gives the wrap to 0..start-1.
  // Fixed priority is the special case start = 0.
  always_comb begin
    hi_found   = 1'b0;
    hi_idx     = '0;
    lo_idx     = '0;
    win_found  = any_req;
    win_onehot = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
      end
      if (req[i] && (!mode || (i >= int'(ptr_d)))) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
    if (win_found) begin
      win_onehot[win_idx] = 1'b1;
    end
  end

  // Next-state logic: load a winner from IDLE, hold while not accepted,
  // and refill or drain on acceptance.
  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = GRANT;
          onehot_d = win_onehot;
          idx_d    = win_idx;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          if (win_found) begin
            onehot_d = win_onehot;
            idx_d    = win_idx;
          end else begin
            state_d  = IDLE;
            onehot_d = '0;
            idx_d    = '0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
        idx_d    = '0;
      end
    endcase
  end

  // State register; the asynchronous reset drops any held grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so all flops update
    // together from the values they had before the edge.
    if (rst) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
    end
  end

  // Output decode: the payload registers are already cleared whenever the slot is empty.
  always_comb begin
    grant_valid  = (state_q == GRANT);
    grant_onehot = onehot_q;
    grant_idx    = idx_q;
    rr_ptr       = ptr_q;
  end

endmodule
